multi_mod_counter: RTL and testbench
====================================

# multi_mod_counter

Bank of CHANNELS independent modulo counters with a runtime-programmable modulus, per-channel enable, up/down direction, synchronous load and a terminal-count pulse. It is the parameterised successor of the single fixed-modulus counter. It sits in timer and sequencing logic, where several phase or slot counters with different periods must run from one clock.

## Interface
- CHANNELS, 4, number of independent counter channels (1..16)
- WIDTH, 32, bits per counter and per modulus
- DEFAULT_MOD, 256, modulus loaded into every channel at reset (must fit in WIDTH bits)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  CHANNELS  per-channel count enable
- dir  in  CHANNELS  per-channel direction; 1 = up, 0 = down
- load  in  CHANNELS  per-channel synchronous load strobe
- load_value  in  CHANNELS*WIDTH  load data; channel i at [i*WIDTH +: WIDTH]
- mod_we  in  CHANNELS  per-channel modulus write strobe
- mod_value  in  CHANNELS*WIDTH  new modulus; channel i at [i*WIDTH +: WIDTH]
- count  out  CHANNELS*WIDTH  registered counter values, same packing
- tc  out  CHANNELS  registered one-cycle terminal-count (wrap) pulse per channel
- any_tc  out  1  registered OR of all tc bits

## Operation
- Per channel state: count register c, modulus register M; channels fully independent.
- Effective top T = M-1; M=0 means full range, T = 2^WIDTH-1.
- Priority per channel each cycle: rst > load > en. dir is ignored when en=0.
- rst: c=0, M=DEFAULT_MOD, tc=0, any_tc=0, all channels.
- mod_we: M <= mod_value. Independent of load/en; the count step in the same cycle uses the old M.
- load: c <= min(load_value, T'), where T' is derived from mod_value if mod_we is asserted in the same cycle, otherwise from the current M. No tc on load. load overrides en.
- Up count (en=1, dir=1): if c >= T, then c <= 0 and tc=1; else c <= c+1. The >= comparison handles M lowered below the current c: next enabled up-step wraps to 0 with tc.
- Down count (en=1, dir=0): if c == 0, then c <= T and tc=1; else if c > T (stale after M lowered), then c <= T with no tc; else c <= c-1.
- M=1: T=0; c stays 0 and tc=1 on every enabled cycle in either direction.
- tc=0 in any cycle without a wrap; tc never asserts while rst or load is active for that channel.
- Arithmetic is WIDTH-bit unsigned modulo 2^WIDTH. No intermediate value exceeds WIDTH bits except the compare of T with M=0, which must be handled explicitly.
- Reset mid-count overrides everything. The cycle after rst deasserts, counting resumes from 0 with DEFAULT_MOD.

## Timing
- Single clock domain. All outputs are registered, with no combinational input-to-output path.
- Latency 1: inputs sampled at edge k; count/tc/any_tc reflect them after edge k.
- tc is high in the same cycle that count shows the wrapped value (0 for up, T for down). Width is exactly 1 cycle per wrap; consecutive wraps (M=1) give continuous high.
- any_tc is the OR of tc of the same cycle (registered from the same next-state terms, not from tc).
- A modulus write at edge k affects count steps from edge k+1 on.

## Test plan
- Reset then en=1, dir=1, ch0 for 256 cycles -> count0 runs 0..255, 0; tc0 and any_tc high only in the cycle count0=0 after 255; other channels held at 0.
- ch1: mod_we with mod_value=5, then up for 12 cycles -> 1,2,3,4,0,1,2,3,4,0,1,2; tc1 high at both zeros. Then dir=0 -> 1,0,4(tc),3.
- ch2 count at 200 with M=256, write M=10, then up -> next value 0 with tc. Repeat with down -> 9 without tc, then 8.
- ch3 load=1 with en=1, load_value=1000, M=256 -> count3=255, tc3=0. Same cycle mod_we=2000 -> count3=1000.
- M=0, WIDTH=8 build, load 255, up -> 0 with tc. M=1 -> count stays 0, tc continuously high while en.
- rst asserted mid-count on all channels with simultaneous load/mod_we -> all count=0, tc=0, M=DEFAULT_MOD next cycle.

Source files
------------

// File: rtl/multi_mod_counter.sv
// multi_mod_counter: bank of independent modulo counters sharing one clock.
// Each channel has a programmable modulus, enable, up/down direction,
// synchronous load and a one-cycle terminal-count pulse on wrap.
module multi_mod_counter #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_MOD = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         en,
  input  logic [CHANNELS-1:0]         dir,
  input  logic [CHANNELS-1:0]         load,
  input  logic [CHANNELS*WIDTH-1:0]   load_value,
  input  logic [CHANNELS-1:0]         mod_we,
  input  logic [CHANNELS*WIDTH-1:0]   mod_value,
  output logic [CHANNELS*WIDTH-1:0]   count,
  output logic [CHANNELS-1:0]         tc,
  output logic                        any_tc
);

  localparam logic [WIDTH-1:0] DEF_MOD = WIDTH'(DEFAULT_MOD);

  logic [WIDTH-1:0] cnt_q   [CHANNELS];
  logic [WIDTH-1:0] mod_q   [CHANNELS];
  logic [WIDTH-1:0] cnt_d   [CHANNELS];
  logic [WIDTH-1:0] mod_d   [CHANNELS];
  logic [WIDTH-1:0] top_cur [CHANNELS];
  logic [WIDTH-1:0] top_ld  [CHANNELS];
  logic [WIDTH-1:0] ld_val  [CHANNELS];
  logic [CHANNELS-1:0] tc_d;

  // Effective top per channel; a modulus of 0 selects the full counter range.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ld_val[i]  = load_value[i*WIDTH +: WIDTH];
      top_cur[i] = (mod_q[i] == '0) ? '1 : mod_q[i] - WIDTH'(1);
      if (mod_we[i]) begin
        top_ld[i] = (mod_value[i*WIDTH +: WIDTH] == '0) ? '1
                  : mod_value[i*WIDTH +: WIDTH] - WIDTH'(1);
      end else begin
        top_ld[i] = top_cur[i];
      end
    end
  end

  // Next count, modulus and wrap pulse; load beats enable, count steps use the old modulus.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      mod_d[i] = mod_we[i] ? mod_value[i*WIDTH +: WIDTH] : mod_q[i];
      tc_d[i]  = 1'b0;
      if (load[i]) begin
        cnt_d[i] = (ld_val[i] > top_ld[i]) ? top_ld[i] : ld_val[i];
      end else if (en[i]) begin
        if (dir[i]) begin
          if (cnt_q[i] >= top_cur[i]) begin
            cnt_d[i] = '0;
            tc_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
          end
        end else begin
          if (cnt_q[i] == '0) begin
            cnt_d[i] = top_cur[i];
            tc_d[i]  = 1'b1;
          end else if (cnt_q[i] > top_cur[i]) begin
            cnt_d[i] = top_cur[i];
          end else begin
            cnt_d[i] = cnt_q[i] - WIDTH'(1);
          end
        end
      end
    end
  end

  // State registers; reset restores zero counts and the default modulus.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        mod_q[i] <= DEF_MOD;
      end
      tc     <= '0;
      any_tc <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        mod_q[i] <= mod_d[i];
      end
      tc     <= tc_d;
      any_tc <= |tc_d;
    end
  end

  // Pack channel counts onto the flat output bus.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      count[i*WIDTH +: WIDTH] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_multi_mod_counter.sv
// tb_multi_mod_counter: directed vectors with hand-computed expectations.
module tb_multi_mod_counter;

  localparam int CH = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en, dir, load, mod_we;
  logic [CH*W-1:0] load_value, mod_value;
  logic [CH*W-1:0] count;
  logic [CH-1:0]   tc;
  logic            any_tc;

  int n_tests = 0;
  int n_fail  = 0;

  multi_mod_counter #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_MOD(256)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_value(load_value), .mod_we(mod_we), .mod_value(mod_value),
    .count(count), .tc(tc), .any_tc(any_tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] cnt(input int ch);
    return count[ch*W +: W];
  endfunction

  task automatic set_lv(input int ch, input logic [W-1:0] v);
    load_value[ch*W +: W] = v;
  endtask

  task automatic set_mv(input int ch, input logic [W-1:0] v);
    mod_value[ch*W +: W] = v;
  endtask

  task automatic idle();
    en = '0; dir = '0; load = '0; mod_we = '0;
  endtask

  // Channel 3 check helper: count, tc bit and any_tc (only channel 3 active).
  task automatic chk3(input string tag, input logic [W-1:0] c, input logic t);
    chk({tag, "_cnt"}, cnt(3), c);
    chk({tag, "_tc"}, W'(tc[3]), W'(t));
    chk({tag, "_any"}, W'(any_tc), W'(t));
  endtask

  initial begin
    logic [W-1:0] dn_exp [4];
    logic         dn_tc  [4];
    rst = 1'b1; idle(); load_value = '0; mod_value = '0;
    step(); step();
    for (int i = 0; i < CH; i++) chk("rst_cnt", cnt(i), '0);
    chk("rst_tc", W'(tc), '0);
    chk("rst_any", W'(any_tc), '0);
    rst = 1'b0;

    // ch0 full default-modulus up run
    en[0] = 1'b1; dir[0] = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      step();
      chk("ch0_up_cnt", cnt(0), W'(k % 256));
      chk("ch0_up_tc", W'(tc[0]), W'(k == 256));
      chk("ch0_up_any", W'(any_tc), W'(k == 256));
    end
    chk("ch0_others1", cnt(1), '0);
    chk("ch0_others3", cnt(3), '0);
    idle();

    // ch1 modulus 5, up then down
    mod_we[1] = 1'b1; set_mv(1, 5);
    step();
    chk("ch1_modwr_cnt", cnt(1), '0);
    idle(); en[1] = 1'b1; dir[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("ch1_up_cnt", cnt(1), W'(k % 5));
      chk("ch1_up_tc", W'(tc[1]), W'((k % 5) == 0));
    end
    dir[1] = 1'b0;
    dn_exp = '{1, 0, 4, 3};
    dn_tc  = '{0, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ch1_dn_cnt", cnt(1), dn_exp[k]);
      chk("ch1_dn_tc", W'(tc[1]), W'(dn_tc[k]));
      chk("ch1_dn_any", W'(any_tc), W'(dn_tc[k]));
    end
    idle();

    // ch2 modulus lowered below current count
    load[2] = 1'b1; set_lv(2, 200);
    step();
    chk("ch2_ld200", cnt(2), 200);
    idle(); en[2] = 1'b1; dir[2] = 1'b1; mod_we[2] = 1'b1; set_mv(2, 10);
    step();
    chk("ch2_oldmod_step", cnt(2), 201);
    chk("ch2_oldmod_tc", W'(tc[2]), 0);
    mod_we[2] = 1'b0;
    step();
    chk("ch2_up_wrap", cnt(2), 0);
    chk("ch2_up_wrap_tc", W'(tc[2]), 1);
    idle(); load[2] = 1'b1; set_lv(2, 200); mod_we[2] = 1'b1; set_mv(2, 256);
    step();
    chk("ch2_reld200", cnt(2), 200);
    idle(); mod_we[2] = 1'b1; set_mv(2, 10);
    step();
    chk("ch2_hold", cnt(2), 200);
    idle(); en[2] = 1'b1; dir[2] = 1'b0;
    step();
    chk("ch2_dn_stale", cnt(2), 9);
    chk("ch2_dn_stale_tc", W'(tc[2]), 0);
    step();
    chk("ch2_dn_8", cnt(2), 8);
    chk("ch2_dn_8_tc", W'(tc[2]), 0);
    idle();

    // ch3 load clamping, load over enable, same-cycle modulus write
    load[3] = 1'b1; en[3] = 1'b1; dir[3] = 1'b1; set_lv(3, 1000);
    step();
    chk3("ch3_ld_clamp", 255, 0);
    mod_we[3] = 1'b1; set_mv(3, 2000);
    step();
    chk3("ch3_ld_newmod", 1000, 0);
    idle(); en[3] = 1'b1; dir[3] = 1'b1;
    step();
    chk3("ch3_up_1001", 1001, 0);

    // ch3 modulus 0: full range
    idle(); load[3] = 1'b1; set_lv(3, 32'hFFFF_FFFF); mod_we[3] = 1'b1; set_mv(3, 0);
    step();
    chk3("m0_ld_max", 32'hFFFF_FFFF, 0);
    idle(); en[3] = 1'b1; dir[3] = 1'b1;
    step();
    chk3("m0_up_wrap", 0, 1);
    step();
    chk3("m0_up_1", 1, 0);
    dir[3] = 1'b0;
    step();
    chk3("m0_dn_0", 0, 0);
    step();
    chk3("m0_dn_wrap", 32'hFFFF_FFFF, 1);

    // ch3 modulus 1: stuck at 0, tc every enabled cycle
    idle(); mod_we[3] = 1'b1; set_mv(3, 1);
    step();
    chk3("m1_hold", 32'hFFFF_FFFF, 0);
    idle(); en[3] = 1'b1; dir[3] = 1'b1;
    step();
    chk3("m1_up_a", 0, 1);
    step();
    chk3("m1_up_b", 0, 1);
    dir[3] = 1'b0;
    step();
    chk3("m1_dn", 0, 1);
    en[3] = 1'b0;
    step();
    chk3("m1_dis", 0, 0);

    // reset mid-count with simultaneous load and modulus writes
    idle(); en = '1; dir = '1;
    step(); step();
    rst = 1'b1; load = '1; mod_we = '1;
    for (int i = 0; i < CH; i++) begin set_lv(i, 7); set_mv(i, 3); end
    step();
    for (int i = 0; i < CH; i++) chk("rst_mid_cnt", cnt(i), '0);
    chk("rst_mid_tc", W'(tc), '0);
    chk("rst_mid_any", W'(any_tc), '0);
    rst = 1'b0; idle();
    load[0] = 1'b1; set_lv(0, 300);
    en[1] = 1'b1; dir[1] = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    chk("post_rst_ld_clamp", cnt(0), 255);
    chk("post_rst_ch1_run", cnt(1), 5);
    chk("post_rst_ch1_tc", W'(tc[1]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
